neuron_acc_ctrl: RTL and testbench

Sequencing controller that owns the pipelined 16-input adder tree in the binary neural net datapath. Upstream popcount/XNOR stages deliver 16-lane chunks under a valid/ready handshake. The controller tracks every chunk through the adder tree's fixed latency and accumulates each neuron's chunk sums into one saturating signed total. Finished neuron totals are queued in a small output FIFO, and the controller applies back-pressure so the non-stallable adder tree never produces a result with nowhere to go.

---
 rtl/neuron_acc_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_neuron_acc_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_acc_ctrl.sv
// Sequencing controller around a fixed-latency adder tree: it tags chunks through the pipe,
// keeps a saturating total per neuron, and queues finished totals in a credit-protected FWFT FIFO.
module neuron_acc_ctrl #(
   parameter int WIDTH_IN  = 8,
   parameter int ADD_LAT   = 2,
   parameter int ACC_W     = WIDTH_IN + 16,
   parameter int OUT_DEPTH = 4,
   parameter int CNT_W     = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [CNT_W-1:0]            cfg_num_chunks,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic signed [WIDTH_IN+10:0] add_sum,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic signed [ACC_W-1:0]     out_data,
   output logic                        out_sign,
   output logic                        out_sat,
   output logic                        busy
);
   localparam int SUM_W = WIDTH_IN + 11;
   localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
   localparam int CRD_W = $clog2(OUT_DEPTH + ADD_LAT + 2) + 1;

   typedef enum logic [0:0] {IDLE = 1'b0, FEED = 1'b1} feed_state_t;

   feed_state_t             state, state_next;
   logic [CNT_W-1:0]        chunk_cnt, chunk_cnt_next, num_lat, num_lat_next, cfg_n;
   logic [ADD_LAT-1:0]      tag_valid, tag_first, tag_last;
   logic signed [ACC_W-1:0] acc, acc_next;
   logic                    sat_flag, sat_next, acc_ovf;
   logic signed [ACC_W-1:0] data_mem [OUT_DEPTH];
   logic [OUT_DEPTH-1:0]    sat_mem;
   logic [PTR_W-1:0]        rd_ptr, wr_ptr;
   logic [CRD_W-1:0]        fifo_count, pend_last;
   logic                    accept, next_first, next_last;
   logic                    ret_valid, ret_first, ret_last, push, pop;

   // Add a sign-extended adder sum to the base; returns {saturated, clamped_value}.
   function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] base,
                                              input logic [SUM_W-1:0] addend);
      logic [ACC_W:0] wide;
      wide = {base[ACC_W-1], base} + {{(ACC_W+1-SUM_W){addend[SUM_W-1]}}, addend};
      if (wide[ACC_W] != wide[ACC_W-1]) begin
         sat_add = {1'b1, wide[ACC_W], {(ACC_W-1){~wide[ACC_W]}}};
      end else begin
         sat_add = {1'b0, wide[ACC_W-1:0]};
      end
   endfunction

   // Circular FIFO pointer advance that also works for non-power-of-two depths.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(OUT_DEPTH - 1)) begin
         ptr_inc = {PTR_W{1'b0}};
      end else begin
         ptr_inc = p + PTR_W'(1);
      end
   endfunction

   assign cfg_n  = (cfg_num_chunks == {CNT_W{1'b0}}) ? CNT_W'(1) : cfg_num_chunks;
   assign accept = in_valid && in_ready;

   // Tag for the chunk that would be accepted now; independent of in_valid so in_ready is too.
   always_comb begin
      next_first = 1'b0;
      next_last  = 1'b0;
      case (state)
         IDLE: begin
            next_first = 1'b1;
            next_last  = (cfg_n == CNT_W'(1));
         end
         FEED: begin
            next_first = 1'b0;
            next_last  = (chunk_cnt == (num_lat - CNT_W'(1)));
         end
         default: begin
            next_first = 1'b0;
            next_last  = 1'b0;
         end
      endcase
   end

   // Feed FSM next-state: N is latched only on the first chunk of a neuron.
   always_comb begin
      state_next     = state;
      chunk_cnt_next = chunk_cnt;
      num_lat_next   = num_lat;
      if (accept) begin
         if (state == IDLE) begin
            num_lat_next   = cfg_n;
            chunk_cnt_next = CNT_W'(1);
         end else begin
            chunk_cnt_next = chunk_cnt + CNT_W'(1);
         end
         state_next = next_last ? IDLE : FEED;
      end else begin
         state_next = state;
      end
   end

   // Feed FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         chunk_cnt <= {CNT_W{1'b0}};
         num_lat   <= {CNT_W{1'b0}};
      end else begin
         state     <= state_next;
         chunk_cnt <= chunk_cnt_next;
         num_lat   <= num_lat_next;
      end
   end

   // Tag pipeline mirrors the adder tree latency; idle cycles shift in an invalid entry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tag_valid <= {ADD_LAT{1'b0}};
         tag_first <= {ADD_LAT{1'b0}};
         tag_last  <= {ADD_LAT{1'b0}};
      end else begin
         tag_valid[0] <= accept;
         tag_first[0] <= accept && next_first;
         tag_last[0]  <= accept && next_last;
         for (int i = 1; i < ADD_LAT; i++) begin
            tag_valid[i] <= tag_valid[i-1];
            tag_first[i] <= tag_first[i-1];
            tag_last[i]  <= tag_last[i-1];
         end
      end
   end

   assign ret_valid = tag_valid[ADD_LAT-1];
   assign ret_first = tag_first[ADD_LAT-1];
   assign ret_last  = tag_last[ADD_LAT-1];

   // Every in-flight last tag already owns a FIFO slot.
   always_comb begin
      pend_last = {CRD_W{1'b0}};
      for (int i = 0; i < ADD_LAT; i++) begin
         if (tag_valid[i] && tag_last[i]) begin
            pend_last = pend_last + CRD_W'(1);
         end else begin
            pend_last = pend_last;
         end
      end
   end

   assign in_ready = (fifo_count + pend_last + CRD_W'(next_last)) <= CRD_W'(OUT_DEPTH);

   assign {acc_ovf, acc_next} = sat_add(ret_first ? {ACC_W{1'b0}} : acc, add_sum);
   assign sat_next = (ret_first ? 1'b0 : sat_flag) | acc_ovf;
   assign push     = ret_valid && ret_last;
   assign pop      = out_valid && out_ready;

   // Running neuron total and its sticky saturation flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc      <= {ACC_W{1'b0}};
         sat_flag <= 1'b0;
      end else if (ret_valid) begin
         acc      <= acc_next;
         sat_flag <= sat_next;
      end else begin
         acc      <= acc;
         sat_flag <= sat_flag;
      end
   end

   // Result FIFO storage, pointers and occupancy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < OUT_DEPTH; i++) begin
            data_mem[i] <= {ACC_W{1'b0}};
         end
         sat_mem    <= {OUT_DEPTH{1'b0}};
         rd_ptr     <= {PTR_W{1'b0}};
         wr_ptr     <= {PTR_W{1'b0}};
         fifo_count <= {CRD_W{1'b0}};
      end else begin
         if (push) begin
            data_mem[wr_ptr] <= acc_next;
            sat_mem[wr_ptr]  <= sat_next;
            wr_ptr           <= ptr_inc(wr_ptr);
         end
         if (pop) begin
            rd_ptr <= ptr_inc(rd_ptr);
         end
         fifo_count <= fifo_count + CRD_W'(push) - CRD_W'(pop);
      end
   end

   assign out_valid = (fifo_count != {CRD_W{1'b0}});
   assign out_data  = data_mem[rd_ptr];
   assign out_sign  = ~out_data[ACC_W-1];
   assign out_sat   = sat_mem[rd_ptr];
   assign busy      = (state == FEED) || (|tag_valid);
endmodule

// File: tb/tb_neuron_acc_ctrl.sv
// Self-checking bench for neuron_acc_ctrl: models the adder tree latency and checks neuron
// totals, saturation, credit back-pressure and reset against a per-chunk arithmetic model.
module tb_neuron_acc_ctrl;
   localparam int WIDTH_IN  = 8;
   localparam int ADD_LAT   = 2;
   localparam int ACC_W     = WIDTH_IN + 16;
   localparam int SAT_W     = WIDTH_IN + 11;
   localparam int OUT_DEPTH = 4;
   localparam int CNT_W     = 8;
   localparam int SUM_W     = WIDTH_IN + 11;
   localparam longint MAX_A = (64'sd1 <<< (ACC_W - 1)) - 64'sd1;
   localparam longint MAX_S = (64'sd1 <<< (SAT_W - 1)) - 64'sd1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [CNT_W-1:0] cfg_num_chunks = '0;
   logic in_valid = 1'b0, out_ready = 1'b0;
   logic signed [SUM_W-1:0] add_sum, chunk_sum = '0;
   logic signed [SUM_W-1:0] sum_pipe [ADD_LAT];
   logic in_ready, out_valid, out_sign, out_sat, busy;
   logic signed [ACC_W-1:0] out_data;
   logic s_in_ready, s_out_valid, s_out_sign, s_out_sat, s_busy;
   logic signed [SAT_W-1:0] s_out_data;

   int n_checks = 0, n_pass = 0;
   int cyc = 0, rdy_err = 0, ovf_err = 0, accepted = 0, outstanding = 0;
   int first_valid_cyc = -1, busy_fall_cyc = -1;
   bit prev_busy = 1'b0, acc_now = 1'b0;
   int m_left = 0;
   longint m_acc = 0, m_acc_s = 0;
   bit m_sat = 1'b0, m_sat_s = 1'b0;
   longint exp_data[$], exp_data_s[$], got_data[$], got_data_s[$];
   bit exp_sat[$], exp_sat_s[$], got_sat[$], got_sat_s[$], got_sign[$];

   neuron_acc_ctrl #(.WIDTH_IN(WIDTH_IN), .ADD_LAT(ADD_LAT), .ACC_W(ACC_W),
                     .OUT_DEPTH(OUT_DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .cfg_num_chunks(cfg_num_chunks), .in_valid(in_valid),
      .in_ready(in_ready), .add_sum(add_sum), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_sign(out_sign), .out_sat(out_sat), .busy(busy));

   neuron_acc_ctrl #(.WIDTH_IN(WIDTH_IN), .ADD_LAT(ADD_LAT), .ACC_W(SAT_W),
                     .OUT_DEPTH(OUT_DEPTH), .CNT_W(CNT_W)) dut_sat (
      .clk(clk), .rst(rst), .cfg_num_chunks(cfg_num_chunks), .in_valid(in_valid),
      .in_ready(s_in_ready), .add_sum(add_sum), .out_valid(s_out_valid), .out_ready(out_ready),
      .out_data(s_out_data), .out_sign(s_out_sign), .out_sat(s_out_sat), .busy(s_busy));

   always #5 clk = ~clk;

   // Adder tree stand-in: accepted chunk sums appear ADD_LAT cycles later, garbage otherwise.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < ADD_LAT; i++) sum_pipe[i] <= '0;
      end else begin
         sum_pipe[0] <= acc_now ? chunk_sum : SUM_W'($urandom);
         for (int i = 1; i < ADD_LAT; i++) sum_pipe[i] <= sum_pipe[i-1];
      end
   end
   assign add_sum = sum_pipe[ADD_LAT-1];

   function automatic longint clamp(input longint v, input longint mx, inout bit sat);
      if (v > mx) begin sat = 1'b1; return mx; end
      if (v < -mx - 1) begin sat = 1'b1; return -mx - 1; end
      return v;
   endfunction

   task automatic model_accept(input longint s, input int n);
      if (m_left == 0) begin
         m_left = n; m_acc = 0; m_acc_s = 0; m_sat = 1'b0; m_sat_s = 1'b0;
      end
      m_acc   = clamp(m_acc + s, MAX_A, m_sat);
      m_acc_s = clamp(m_acc_s + s, MAX_S, m_sat_s);
      m_left--;
      if (m_left == 0) begin
         exp_data.push_back(m_acc);     exp_sat.push_back(m_sat);
         exp_data_s.push_back(m_acc_s); exp_sat_s.push_back(m_sat_s);
         outstanding++;
      end
   endtask

   task automatic clear_obs();
      exp_data.delete(); exp_sat.delete(); exp_data_s.delete(); exp_sat_s.delete();
      got_data.delete(); got_sat.delete(); got_data_s.delete(); got_sat_s.delete();
      got_sign.delete();
   endtask

   // One clock cycle: drive, observe mid-cycle, update the model, move past the edge.
   task automatic step(input logic v, input logic signed [SUM_W-1:0] s, input logic ordy);
      int n;
      bit nxt_last, exp_rdy;
      in_valid = v; chunk_sum = s; out_ready = ordy; acc_now = 1'b0;
      @(negedge clk);
      n = (cfg_num_chunks == '0) ? 1 : int'(cfg_num_chunks);
      nxt_last = (m_left == 1) || (m_left == 0 && n == 1);
      exp_rdy = (outstanding + (nxt_last ? 1 : 0)) <= OUT_DEPTH;
      if (in_ready !== exp_rdy || s_in_ready !== exp_rdy) rdy_err++;
      if (s_out_valid !== out_valid) rdy_err++;
      if (out_valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (prev_busy && busy === 1'b0 && busy_fall_cyc < 0) busy_fall_cyc = cyc;
      prev_busy = (busy === 1'b1);
      if (in_valid && in_ready) begin
         acc_now = 1'b1;
         accepted++;
         model_accept(longint'(s), n);
      end
      if (out_valid && out_ready) begin
         got_data.push_back(longint'(out_data)); got_sat.push_back(out_sat);
         got_sign.push_back(out_sign);
         got_data_s.push_back(longint'(s_out_data)); got_sat_s.push_back(s_out_sat);
         outstanding--;
      end
      if (outstanding > OUT_DEPTH) ovf_err++;
      @(posedge clk); #1;
      cyc++;
   endtask

   task automatic drain(input int max_cyc);
      for (int i = 0; i < max_cyc && outstanding > 0; i++) step(1'b0, SUM_W'($urandom), 1'b1);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({in_ready, out_valid, out_sign, out_sat, busy} !== 5'b10100)
         $display("FAIL reset_flags: got %b expected 10100", {in_ready, out_valid, out_sign, out_sat, busy});
      else n_pass++;
      n_checks++;
      if (out_data !== '0 || s_out_data !== '0)
         $display("FAIL reset_data: got %0d/%0d expected 0", out_data, s_out_data);
      else n_pass++;
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      int t0;
      clear_obs(); first_valid_cyc = -1; busy_fall_cyc = -1;
      cfg_num_chunks = 8'd4; t0 = cyc;
      step(1'b1, SUM_W'(10), 1'b0); step(1'b1, SUM_W'(20), 1'b0);
      step(1'b1, SUM_W'(-5), 1'b0); step(1'b1, SUM_W'(7), 1'b0);
      for (int i = 0; i < 6; i++) step(1'b0, SUM_W'($urandom), 1'b0);
      n_checks++;
      if (first_valid_cyc !== t0 + 3 + ADD_LAT + 1)
         $display("FAIL basic_latency: got cycle %0d expected %0d", first_valid_cyc, t0 + 3 + ADD_LAT + 1);
      else n_pass++;
      n_checks++;
      if (busy_fall_cyc !== t0 + 3 + ADD_LAT + 1)
         $display("FAIL basic_busy_fall: got cycle %0d expected %0d", busy_fall_cyc, t0 + 3 + ADD_LAT + 1);
      else n_pass++;
      drain(20);
      for (int i = 0; i < 4; i++) step(1'b0, SUM_W'($urandom), 1'b1);
      n_checks++;
      if (got_data.size() !== 1) $display("FAIL basic_count: got %0d expected 1", got_data.size());
      else n_pass++;
      if (got_data.size() == 1) begin
         n_checks++;
         if (got_data[0] !== 64'sd32 || got_sign[0] !== 1'b1 || got_sat[0] !== 1'b0)
            $display("FAIL basic_result: got %0d sign %0d sat %0d expected 32 1 0", got_data[0], got_sign[0], got_sat[0]);
         else n_pass++;
      end
   endtask

   task automatic test_single();
      clear_obs();
      cfg_num_chunks = 8'd0; step(1'b1, SUM_W'(-3), 1'b0);
      cfg_num_chunks = 8'd1; step(1'b1, SUM_W'(0), 1'b0);
      drain(20);
      n_checks++;
      if (got_data.size() !== 2) $display("FAIL single_count: got %0d expected 2", got_data.size());
      else n_pass++;
      if (got_data.size() == 2) begin
         n_checks++;
         if (got_data[0] !== -64'sd3 || got_sign[0] !== 1'b0)
            $display("FAIL single_neg: got %0d sign %0d expected -3 0", got_data[0], got_sign[0]);
         else n_pass++;
         n_checks++;
         if (got_data[1] !== 64'sd0 || got_sign[1] !== 1'b1)
            $display("FAIL single_zero: got %0d sign %0d expected 0 1", got_data[1], got_sign[1]);
         else n_pass++;
      end
   endtask

   task automatic test_saturation();
      logic signed [SUM_W-1:0] max_sum;
      clear_obs();
      max_sum = {1'b0, {(SUM_W-1){1'b1}}};
      cfg_num_chunks = 8'd3;
      for (int i = 0; i < 3; i++) step(1'b1, max_sum, 1'b0);
      cfg_num_chunks = 8'd1; step(1'b1, SUM_W'(5), 1'b0);
      drain(20);
      n_checks++;
      if (got_data_s.size() !== 2) $display("FAIL sat_count: got %0d expected 2", got_data_s.size());
      else n_pass++;
      if (got_data_s.size() == 2) begin
         n_checks++;
         if (got_data_s[0] !== MAX_S || got_sat_s[0] !== 1'b1)
            $display("FAIL sat_clamp: got %0d sat %0d expected %0d 1", got_data_s[0], got_sat_s[0], MAX_S);
         else n_pass++;
         n_checks++;
         if (got_data_s[1] !== 64'sd5 || got_sat_s[1] !== 1'b0)
            $display("FAIL sat_next_clear: got %0d sat %0d expected 5 0", got_data_s[1], got_sat_s[1]);
         else n_pass++;
         n_checks++;
         if (got_data[0] !== 3 * MAX_S || got_sat[0] !== 1'b0)
            $display("FAIL sat_wide: got %0d sat %0d expected %0d 0", got_data[0], got_sat[0], 3 * MAX_S);
         else n_pass++;
      end
   endtask

   task automatic test_cfg_change();
      clear_obs();
      cfg_num_chunks = 8'd3; step(1'b1, SUM_W'(1), 1'b0);
      cfg_num_chunks = 8'd5; step(1'b1, SUM_W'(2), 1'b0); step(1'b1, SUM_W'(3), 1'b0);
      step(1'b1, SUM_W'(10), 1'b0);
      cfg_num_chunks = 8'd2;
      for (int i = 2; i <= 5; i++) step(1'b1, SUM_W'(10 * i), 1'b0);
      drain(30);
      n_checks++;
      if (got_data.size() !== 2) $display("FAIL cfg_count: got %0d expected 2", got_data.size());
      else n_pass++;
      if (got_data.size() == 2) begin
         n_checks++;
         if (got_data[0] !== 64'sd6 || got_data[1] !== 64'sd150)
            $display("FAIL cfg_totals: got %0d,%0d expected 6,150", got_data[0], got_data[1]);
         else n_pass++;
      end
   endtask

   task automatic test_back_to_back();
      int acc0;
      clear_obs(); acc0 = accepted;
      cfg_num_chunks = 8'd1;
      for (int i = 0; i < 12; i++) step(1'b1, SUM_W'($urandom), 1'b0);
      n_checks++;
      if (accepted - acc0 !== OUT_DEPTH)
         $display("FAIL bp_accepted: got %0d expected %0d", accepted - acc0, OUT_DEPTH);
      else n_pass++;
      n_checks++;
      if (in_ready !== 1'b0) $display("FAIL bp_ready_low: got %b expected 0", in_ready);
      else n_pass++;
      step(1'b1, SUM_W'($urandom), 1'b1);
      n_checks++;
      if (in_ready !== 1'b1 || got_data.size() !== 1)
         $display("FAIL bp_ready_return: got ready %b pops %0d expected 1 1", in_ready, got_data.size());
      else n_pass++;
      step(1'b0, SUM_W'($urandom), 1'b0);
      drain(40);
      n_checks++;
      if (got_data.size() !== exp_data.size() || exp_data.size() < OUT_DEPTH)
         $display("FAIL bp_count: got %0d expected %0d", got_data.size(), exp_data.size());
      else n_pass++;
      for (int i = 0; i < got_data.size() && i < exp_data.size(); i++) begin
         n_checks++;
         if (got_data[i] !== exp_data[i])
            $display("FAIL bp_order[%0d]: got %0d expected %0d", i, got_data[i], exp_data[i]);
         else n_pass++;
      end
   endtask

   task automatic test_random();
      clear_obs();
      for (int i = 0; i < 400; i++) begin
         cfg_num_chunks = CNT_W'($urandom_range(0, 5));
         step($urandom_range(0, 3) != 0, SUM_W'($urandom), $urandom_range(0, 2) != 0);
      end
      while (m_left != 0) step(1'b1, SUM_W'($urandom), 1'b1);
      drain(200);
      n_checks++;
      if (got_data.size() !== exp_data.size() || exp_data.size() == 0)
         $display("FAIL rand_count: got %0d expected %0d", got_data.size(), exp_data.size());
      else n_pass++;
      for (int i = 0; i < got_data.size() && i < exp_data.size(); i++) begin
         n_checks++;
         if (got_data[i] !== exp_data[i] || got_sat[i] !== exp_sat[i] ||
             got_sign[i] !== (exp_data[i] >= 0) ||
             got_data_s[i] !== exp_data_s[i] || got_sat_s[i] !== exp_sat_s[i])
            $display("FAIL rand_result[%0d]: got %0d/%0d %0d/%0d expected %0d/%0d %0d/%0d", i,
                     got_data[i], got_sat[i], got_data_s[i], got_sat_s[i],
                     exp_data[i], exp_sat[i], exp_data_s[i], exp_sat_s[i]);
         else n_pass++;
      end
      n_checks++;
      if (rdy_err !== 0 || ovf_err !== 0)
         $display("FAIL credit: got %0d ready errors %0d overflows expected 0 0", rdy_err, ovf_err);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      clear_obs();
      cfg_num_chunks = 8'd4;
      step(1'b1, SUM_W'(100), 1'b0); step(1'b1, SUM_W'(200), 1'b0); step(1'b1, SUM_W'(300), 1'b0);
      n_checks++;
      if (busy !== 1'b1) $display("FAIL rmid_busy: got %b expected 1", busy);
      else n_pass++;
      rst = 1'b1; in_valid = 1'b0; acc_now = 1'b0;
      #2;
      n_checks++;
      if ({in_ready, out_valid, out_sign, out_sat, busy} !== 5'b10100 || out_data !== '0)
         $display("FAIL rmid_outputs: got %b data %0d expected 10100 0",
                  {in_ready, out_valid, out_sign, out_sat, busy}, out_data);
      else n_pass++;
      @(posedge clk); #1 rst = 1'b0;
      m_left = 0; outstanding = 0; prev_busy = 1'b0; first_valid_cyc = -1;
      for (int i = 0; i < 6; i++) step(1'b0, SUM_W'($urandom), 1'b1);
      n_checks++;
      if (got_data.size() !== 0 || first_valid_cyc >= 0)
         $display("FAIL rmid_no_result: got %0d results expected 0", got_data.size());
      else n_pass++;
      cfg_num_chunks = 8'd2;
      step(1'b1, SUM_W'(7), 1'b0); step(1'b1, SUM_W'(-9), 1'b0);
      drain(20);
      n_checks++;
      if (got_data.size() !== 1 || got_data[0] !== -64'sd2)
         $display("FAIL rmid_fresh: got %0d results first %0d expected 1 -2", got_data.size(),
                  (got_data.size() > 0) ? got_data[0] : 64'sd0);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_single();
      test_saturation();
      test_cfg_change();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
